// File: rtl/fifo_bus_lector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_bus_lector: drains the agent FIFO one word at a time onto the bus   |
// | through a request/grant handshake. Option macro: GRANT_TIMEOUT_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_bus_lector #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pndng_i,
   input  logic [WIDTH-1:0] dato_i,
   output logic             pop_o,
   output logic             bus_req_o,
   input  logic             bus_gnt_i,
   output logic             bus_push_o,
   output logic [WIDTH-1:0] bus_dato_o,
   output logic             busy_o,
   output logic [15:0]      sent_cnt_o,
   output logic             timeout_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_hold;

   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("fifo_bus_lector: TIMEOUT must be at least 1");
   end

`ifdef GRANT_TIMEOUT_EN
   localparam int                c_wait_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);

   logic [c_wait_w-1:0] r_wait;
`else
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_hold     <= '0;
         pop_o      <= 1'b0;
         bus_req_o  <= 1'b0;
         bus_push_o <= 1'b0;
         bus_dato_o <= '0;
         busy_o     <= 1'b0;
         sent_cnt_o <= 16'd0;
`ifdef GRANT_TIMEOUT_EN
         r_wait     <= '0;
         timeout_o  <= 1'b0;
`endif
      end else begin
         pop_o      <= 1'b0;
         bus_push_o <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
         timeout_o  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (pndng_i) begin
                  r_hold    <= dato_i;
                  pop_o     <= 1'b1;
                  bus_req_o <= 1'b1;
                  busy_o    <= 1'b1;
                  r_state   <= S_REQ;
`ifdef GRANT_TIMEOUT_EN
                  r_wait    <= '0;
`endif
               end
            end
            S_REQ: begin
               // A grant arriving on the expiry edge still wins.
               if (bus_gnt_i) begin
                  bus_push_o <= 1'b1;
                  bus_dato_o <= r_hold;
                  r_state    <= S_SEND;
               end
`ifdef GRANT_TIMEOUT_EN
               else if (r_wait == c_wait_last) begin
                  bus_req_o <= 1'b0;
                  busy_o    <= 1'b0;
                  timeout_o <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
`endif
            end
            S_SEND: begin
               bus_req_o  <= 1'b0;
               busy_o     <= 1'b0;
               sent_cnt_o <= sent_cnt_o + 16'd1;
               r_state    <= S_IDLE;
            end
            default: begin
               bus_req_o <= 1'b0;
               busy_o    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_bus_lector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_bus_lector: directed + randomized bench with a FIFO/bus model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fifo_bus_lector;
   localparam int c_w       = 16;
   localparam int c_timeout = 15;

   logic           clk;
   logic           reset;
   logic           pndng_i;
   logic [c_w-1:0] dato_i;
   logic           pop_o;
   logic           bus_req_o;
   logic           bus_gnt_i;
   logic           bus_push_o;
   logic [c_w-1:0] bus_dato_o;
   logic           busy_o;
   logic [15:0]    sent_cnt_o;
   logic           timeout_o;

   fifo_bus_lector #(.WIDTH(c_w), .TIMEOUT(c_timeout)) dut (
      .clk        (clk),
      .reset      (reset),
      .pndng_i    (pndng_i),
      .dato_i     (dato_i),
      .pop_o      (pop_o),
      .bus_req_o  (bus_req_o),
      .bus_gnt_i  (bus_gnt_i),
      .bus_push_o (bus_push_o),
      .bus_dato_o (bus_dato_o),
      .busy_o     (busy_o),
      .sent_cnt_o (sent_cnt_o),
      .timeout_o  (timeout_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int             tests = 0;
   int             fails = 0;
   int             cyc = 0;
   int             last_push = -100;
   int             exp_total = 0;
   logic [c_w-1:0] fifo_q[$];   // words still in the FIFO
   logic [c_w-1:0] sb_q[$];     // words popped, awaiting their bus strobe

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_fifo();
      pndng_i = (fifo_q.size() != 0);
      dato_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic push_word(input logic [c_w-1:0] w);
      fifo_q.push_back(w);
      exp_total++;
      apply_fifo();
   endtask

   // One clock; the FIFO pops on the edge where pop_o was high.
   task automatic step();
      logic was_pop;
      logic was_push;
      logic [c_w-1:0] w;
      was_pop  = pop_o;
      was_push = bus_push_o;
      @(posedge clk);
      #1;
      cyc++;
      if (was_pop) begin
         check("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            sb_q.push_back(w);
         end
      end
      check("pop_one_cycle", 32'(was_pop & pop_o), 32'd0);
      check("push_one_cycle", 32'(was_push & bus_push_o), 32'd0);
      if (bus_push_o) begin
         check("push_gap", 32'(cyc - last_push >= 3), 32'd1);
         last_push = cyc;
         check("push_has_word", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            w = sb_q.pop_front();
            check("bus_word", 32'(bus_dato_o), 32'(w));
         end
      end
      if (timeout_o) begin
         check("drop_has_word", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) void'(sb_q.pop_front());
         exp_total--;
      end
      apply_fifo();
   endtask

   task automatic drain(input int budget, input bit rnd_gnt);
      int n;
      n = 0;
      do begin
         if (rnd_gnt) bus_gnt_i = ($urandom_range(0, 3) != 0);
         step();
         n++;
      end while ((fifo_q.size() != 0 || busy_o || pop_o || sb_q.size() != 0) && n < budget);
      check("drain_complete", 32'(fifo_q.size() != 0 || busy_o || pop_o || sb_q.size() != 0), 32'd0);
      check("sent_cnt", 32'(sent_cnt_o), 32'(exp_total));
   endtask

   initial begin
      int k;
      reset     = 1'b1;
      pndng_i   = 1'b0;
      dato_i    = '0;
      bus_gnt_i = 1'b0;
      #7;
      check("rst_pop", 32'(pop_o), 32'd0);
      check("rst_req", 32'(bus_req_o), 32'd0);
      check("rst_push", 32'(bus_push_o), 32'd0);
      check("rst_dato", 32'(bus_dato_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_cnt", 32'(sent_cnt_o), 32'd0);
      check("rst_timeout", 32'(timeout_o), 32'd0);
      reset = 1'b0;

      // Empty FIFO: nothing moves.
      for (int i = 0; i < 50; i++) begin
         step();
         check("empty_pop", 32'(pop_o), 32'd0);
         check("empty_req", 32'(bus_req_o), 32'd0);
         check("empty_busy", 32'(busy_o), 32'd0);
      end

      // Single word with grant tied high.
      bus_gnt_i = 1'b1;
      push_word(16'h0006);
      drain(20, 1'b0);
      check("single_dato", 32'(bus_dato_o), 32'h0006);

      // Ordering of two words.
      push_word(16'h0006);
      push_word(16'h000A);
      drain(30, 1'b0);
      check("order_last_dato", 32'(bus_dato_o), 32'h000A);

      // Grant withheld for 8 REQ cycles.
      bus_gnt_i = 1'b0;
      push_word(16'h1234);
      step();
      check("gd_pop", 32'(pop_o), 32'd1);
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         check("gd_req_held", 32'(bus_req_o), 32'd1);
         check("gd_no_push", 32'(bus_push_o), 32'd0);
      end
      bus_gnt_i = 1'b1;
      step();
      check("gd_push", 32'(bus_push_o), 32'd1);
      drain(10, 1'b0);

      // Randomized words and grant pattern.
      for (int i = 0; i < 12; i++) push_word(16'($urandom));
      drain(400, 1'b1);
      for (int i = 0; i < 8; i++) push_word(16'($urandom));
      drain(300, 1'b1);

      // Reset while a popped word waits in REQ.
      bus_gnt_i = 1'b0;
      push_word(16'hBEEF);
      step();
      step();
      check("rr_req", 32'(bus_req_o), 32'd1);
      reset = 1'b1;
      #2;
      check("rr_req_clr", 32'(bus_req_o), 32'd0);
      check("rr_busy_clr", 32'(busy_o), 32'd0);
      check("rr_cnt_clr", 32'(sent_cnt_o), 32'd0);
      check("rr_dato_clr", 32'(bus_dato_o), 32'd0);
      sb_q.delete();
      exp_total = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus_gnt_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("rr_no_push", 32'(bus_push_o), 32'd0);
      end
      check("rr_cnt", 32'(sent_cnt_o), 32'd0);

`ifdef GRANT_TIMEOUT_EN
      // Grant never given: the word is dropped after TIMEOUT REQ cycles.
      bus_gnt_i = 1'b0;
      push_word(16'hDEAD);
      step();
      step();
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (timeout_o) begin
            k = i;
            break;
         end
         check("to_req_held", 32'(bus_req_o), 32'd1);
      end
      check("to_latency", 32'(k), 32'(c_timeout - 1));
      check("to_req_drop", 32'(bus_req_o), 32'd0);
      check("to_cnt_same", 32'(sent_cnt_o), 32'(exp_total));
      step();
      check("to_pulse", 32'(timeout_o), 32'd0);
      bus_gnt_i = 1'b1;
      push_word(16'h0042);
      drain(20, 1'b0);
      check("to_next_dato", 32'(bus_dato_o), 32'h0042);
`else
      // Without the timeout option REQ waits indefinitely.
      bus_gnt_i = 1'b0;
      push_word(16'hDEAD);
      step();
      step();
      k = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         k = k + int'(timeout_o) + int'(bus_push_o) + int'(!bus_req_o);
      end
      check("nt_waiting", 32'(k), 32'd0);
      bus_gnt_i = 1'b1;
      drain(20, 1'b0);
      check("nt_dato", 32'(bus_dato_o), 32'hDEAD);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
